pcpi_data_mem: RTL and testbench
================================

PCPI_DATA_MEM -- requirements
Module: pcpi_data_mem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024: RAM size in 32-bit words (power of two, 16..4096).
REQ-002 The block SHALL have parameter WAIT_STATES, default 1: extra cycles between acceptance and response (0..7).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  asynchronous active-high reset.
REQ-006 Port mem_valid  input  1  request from PCPI unit, held until mem_ready.
REQ-007 Port mem_addr  input  32  byte address.
REQ-008 Port mem_wdata  input  32  write data.
REQ-009 Port mem_wstrb  input  4  byte-lane write enables; 4'b0000 means read.
REQ-010 Port mem_ready  output  1  one-cycle completion pulse.
REQ-011 Port mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-012 Port rd_count  output  16  completed reads, saturating.
REQ-013 Port wr_count  output  16  completed writes, saturating.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP, TURN.
REQ-015 IDLE with mem_valid=1 SHALL latch addr/wdata/wstrb and go to WAIT if WAIT_STATES>0, else RESP.
REQ-016 WAIT SHALL count down WAIT_STATES cycles, then go to RESP.
REQ-017 Request latency: mem_ready asserted exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-018 In RESP mem_ready SHALL be 1 for exactly one cycle; next state TURN.
REQ-019 TURN SHALL ignore mem_valid for one cycle (master deasserts), then go to IDLE; back-to-back throughput is one request per WAIT_STATES+3 cycles.
REQ-020 Word index SHALL be mem_addr[31:2]; mem_addr[1:0] ignored.
REQ-021 Writes SHALL update only lanes with mem_wstrb bit set, committed on the edge entering RESP.
REQ-022 Reads SHALL present ram[index] on mem_rdata during RESP; mem_rdata SHALL be 0 outside RESP.
REQ-023 Index >= DEPTH_WORDS: write dropped, read returns 32'hDEADBEEF; still completes with mem_ready.
REQ-024 Inputs SHALL be sampled only at acceptance; changes or mem_valid drop during WAIT/RESP SHALL not affect the transaction, which still completes.
REQ-025 rd_count/wr_count SHALL increment on the RESP cycle (out-of-range included) and hold at 16'hFFFF.
REQ-026 A write followed by a read to the same word SHALL return the new data.

Reset
REQ-027 reset=1 SHALL force state IDLE, mem_ready=0, mem_rdata=0, rd_count=0, wr_count=0, wait counter 0, asynchronously.
REQ-028 Reset during WAIT SHALL abort the request with no RAM write and no mem_ready pulse.
REQ-029 RAM contents SHALL not be cleared by reset.

Configuration
REQ-030 With MEM_BUS_ERR_EN defined, output mem_err (1 bit) SHALL pulse with mem_ready when the accepted index >= DEPTH_WORDS, reset value 0.
REQ-031 Without MEM_BUS_ERR_EN, mem_err SHALL not exist; out-of-range behaviour per REQ-023 is otherwise unchanged.

Verification
REQ-032 WAIT_STATES=1: write 0x12345678 to 0x010 with wstrb=1111, then read 0x010 -> mem_ready 2 cycles after each acceptance, read data 0x12345678, wr_count=1, rd_count=1.
REQ-033 Write 0xAABBCCDD to 0x020 wstrb=1111, then 0x00000011 wstrb=0001, then read -> 0xAABBCC11.
REQ-034 Read byte address 0x1000 with DEPTH_WORDS=1024 -> mem_rdata 0xDEADBEEF; mem_err=1 with MEM_BUS_ERR_EN, port absent without.
REQ-035 WAIT_STATES=3: write to 0x040, assert reset during WAIT -> no mem_ready; subsequent read of 0x040 returns prior contents; counters 0.
REQ-036 mem_valid held high continuously with WAIT_STATES=0 -> one completion every 3 cycles, never two consecutive mem_ready cycles.
REQ-037 Preload counters near limit via 65 540 reads -> rd_count stays 0xFFFF.

Source files
------------

// File: rtl/pcpi_data_mem.sv
// Word-addressed data RAM behind a PCPI-style valid/ready handshake with fixed wait states.
// Define MEM_BUS_ERR_EN to add the mem_err output for out-of-range accesses.
module pcpi_data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`ifdef MEM_BUS_ERR_EN
  ,
  output logic        mem_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;

  state_t      state, next_state;
  logic [2:0]  wait_cnt;
  logic [29:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [29:0] acc_idx;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic        accept, enter_resp, acc_in_range, idx_ok, is_read;
  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] ram_q;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^mem_addr[1:0];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_valid) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (wait_cnt == 3'd0) next_state = RESP;
      RESP:    next_state = TURN;
      TURN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states the RAM is accessed on the acceptance edge itself,
  // so the live inputs must be used instead of the not-yet-latched copies.
  assign accept       = (state == IDLE) && mem_valid;
  assign acc_idx      = (state == IDLE) ? mem_addr[31:2] : idx_q;
  assign acc_wdata    = (state == IDLE) ? mem_wdata : wdata_q;
  assign acc_wstrb    = (state == IDLE) ? mem_wstrb : wstrb_q;
  assign acc_in_range = acc_idx < 30'(DEPTH_WORDS);
  assign enter_resp   = (next_state == RESP) && !reset;

  always_ff @(posedge clk) begin
    if (enter_resp && acc_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) ram[acc_idx[AW-1:0]][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
      ram_q <= ram[acc_idx[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      idx_q    <= 30'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        idx_q    <= mem_addr[31:2];
        wdata_q  <= mem_wdata;
        wstrb_q  <= mem_wstrb;
        wait_cnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != 3'd0)) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (state == RESP) begin
        if (wstrb_q == 4'd0) begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end else begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
      end
    end
  end

  assign is_read   = (wstrb_q == 4'd0);
  assign idx_ok    = idx_q < 30'(DEPTH_WORDS);
  assign mem_ready = (state == RESP);
  assign mem_rdata = (mem_ready && is_read) ? (idx_ok ? ram_q : 32'hDEADBEEF) : 32'h0;

`ifdef MEM_BUS_ERR_EN
  assign mem_err = mem_ready && !idx_ok;
`endif

endmodule

// File: tb/tb_pcpi_data_mem.sv
// Scoreboard bench for pcpi_data_mem: three instances with 1, 3 and 0 wait states.
// Expected read data is queued when a request is driven and popped on mem_ready.
module tb_pcpi_data_mem;

  logic        clk = 1'b0;
  logic        rst    [3];
  logic        valid  [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  wstrb  [3];
  logic        ready  [3];
  logic [31:0] rdata  [3];
  logic [15:0] rd_cnt [3];
  logic [15:0] wr_cnt [3];
`ifdef MEM_BUS_ERR_EN
  logic        err    [3];
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          exp_rd [3];
  int          exp_wr [3];

  always #5 clk = ~clk;

  pcpi_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(rst[0]), .mem_valid(valid[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_ready(ready[0]),
    .mem_rdata(rdata[0]), .rd_count(rd_cnt[0]), .wr_count(wr_cnt[0])
`ifdef MEM_BUS_ERR_EN
    , .mem_err(err[0])
`endif
  );

  pcpi_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(rst[1]), .mem_valid(valid[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_ready(ready[1]),
    .mem_rdata(rdata[1]), .rd_count(rd_cnt[1]), .wr_count(wr_cnt[1])
`ifdef MEM_BUS_ERR_EN
    , .mem_err(err[1])
`endif
  );

  pcpi_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(rst[2]), .mem_valid(valid[2]), .mem_addr(addr[2]),
    .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]), .mem_ready(ready[2]),
    .mem_rdata(rdata[2]), .rd_count(rd_cnt[2]), .wr_count(wr_cnt[2])
`ifdef MEM_BUS_ERR_EN
    , .mem_err(err[2])
`endif
  );

  // One request on instance d; optionally drops valid and scrambles inputs while waiting.
  task automatic run_txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input bit scramble,
                         output logic [31:0] rd, output int lat, output logic ready_next,
                         output logic [31:0] rdata_next, output logic err_o);
    lat   = -1;
    rd    = 32'h0;
    err_o = 1'b0;
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; wstrb[d] = s; valid[d] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready[d]) begin
        lat = i;
        rd  = rdata[d];
`ifdef MEM_BUS_ERR_EN
        err_o = err[d];
`endif
        break;
      end
      if (scramble && i == 1) begin
        valid[d] = 1'b0; addr[d] = ~a; wdata[d] = ~wd; wstrb[d] = 4'hF;
      end
    end
    valid[d] = 1'b0;
    @(negedge clk);
    ready_next = ready[d];
    rdata_next = rdata[d];
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ready[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready[%0d]: got %b expected 0", d, ready[d]); end
      checks++;
      if (rdata[d] !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata[%0d]: got %h expected 0", d, rdata[d]); end
      checks++;
      if (rd_cnt[d] !== 16'h0) begin errors++; $display("[TB] FAIL reset_rd_count[%0d]: got %h expected 0", d, rd_cnt[d]); end
      checks++;
      if (wr_cnt[d] !== 16'h0) begin errors++; $display("[TB] FAIL reset_wr_count[%0d]: got %h expected 0", d, wr_cnt[d]); end
`ifdef MEM_BUS_ERR_EN
      checks++;
      if (err[d] !== 1'b0) begin errors++; $display("[TB] FAIL reset_err[%0d]: got %b expected 0", d, err[d]); end
`endif
      exp_rd[d] = 0;
      exp_wr[d] = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
  endtask

  task automatic test_write_read;
    logic [31:0] rd, rdn, expv; int lat; logic rn, e;
    run_txn(0, 32'h010, 32'h12345678, 4'hF, 1'b0, rd, lat, rn, rdn, e);
    exp_wr[0]++;
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL wr_latency: got %0d expected 2", lat); end
    checks++;
    if (rn !== 1'b0) begin errors++; $display("[TB] FAIL wr_ready_pulse: got %b expected 0", rn); end
    exp_q.push_back(32'h12345678);
    run_txn(0, 32'h010, 32'h0, 4'h0, 1'b0, rd, lat, rn, rdn, e);
    exp_rd[0]++;
    expv = exp_q.pop_front();
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL rd_latency: got %0d expected 2", lat); end
    checks++;
    if (rd !== expv) begin errors++; $display("[TB] FAIL rd_data: got %h expected %h", rd, expv); end
    checks++;
    if (rn !== 1'b0) begin errors++; $display("[TB] FAIL rd_ready_pulse: got %b expected 0", rn); end
    checks++;
    if (rdn !== 32'h0) begin errors++; $display("[TB] FAIL rdata_idle: got %h expected 0", rdn); end
    checks++;
    if (wr_cnt[0] !== 16'(exp_wr[0])) begin errors++; $display("[TB] FAIL wr_count: got %0d expected %0d", wr_cnt[0], exp_wr[0]); end
    checks++;
    if (rd_cnt[0] !== 16'(exp_rd[0])) begin errors++; $display("[TB] FAIL rd_count: got %0d expected %0d", rd_cnt[0], exp_rd[0]); end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd, rdn, expv; int lat; logic rn, e;
    run_txn(0, 32'h020, 32'hAABBCCDD, 4'hF, 1'b0, rd, lat, rn, rdn, e);
    run_txn(0, 32'h020, 32'h00000011, 4'h1, 1'b0, rd, lat, rn, rdn, e);
    exp_wr[0] += 2;
    exp_q.push_back(32'hAABBCC11);
    run_txn(0, 32'h023, 32'h0, 4'h0, 1'b0, rd, lat, rn, rdn, e);
    exp_rd[0]++;
    expv = exp_q.pop_front();
    checks++;
    if (rd !== expv) begin errors++; $display("[TB] FAIL lane_low: got %h expected %h", rd, expv); end
    run_txn(0, 32'h020, 32'h99887766, 4'hA, 1'b0, rd, lat, rn, rdn, e);
    exp_wr[0]++;
    exp_q.push_back(32'h99BB7711);
    run_txn(0, 32'h021, 32'h0, 4'h0, 1'b0, rd, lat, rn, rdn, e);
    exp_rd[0]++;
    expv = exp_q.pop_front();
    checks++;
    if (rd !== expv) begin errors++; $display("[TB] FAIL lane_mixed: got %h expected %h", rd, expv); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd, rdn, expv; int lat; logic rn, e;
    run_txn(0, 32'h000, 32'h0F0F0F0F, 4'hF, 1'b0, rd, lat, rn, rdn, e);
    run_txn(0, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, rd, lat, rn, rdn, e);
    exp_wr[0] += 2;
    checks++;
    if (lat != 2) begin errors++; $display("[TB] FAIL oor_wr_latency: got %0d expected 2", lat); end
    exp_q.push_back(32'hDEADBEEF);
    run_txn(0, 32'h1000, 32'h0, 4'h0, 1'b0, rd, lat, rn, rdn, e);
    exp_rd[0]++;
    expv = exp_q.pop_front();
    checks++;
    if (rd !== expv) begin errors++; $display("[TB] FAIL oor_rdata: got %h expected %h", rd, expv); end
`ifdef MEM_BUS_ERR_EN
    checks++;
    if (e !== 1'b1) begin errors++; $display("[TB] FAIL oor_err: got %b expected 1", e); end
`endif
    exp_q.push_back(32'h0F0F0F0F);
    run_txn(0, 32'h000, 32'h0, 4'h0, 1'b0, rd, lat, rn, rdn, e);
    exp_rd[0]++;
    expv = exp_q.pop_front();
    checks++;
    if (rd !== expv) begin errors++; $display("[TB] FAIL oor_no_alias: got %h expected %h", rd, expv); end
`ifdef MEM_BUS_ERR_EN
    checks++;
    if (e !== 1'b0) begin errors++; $display("[TB] FAIL inrange_err: got %b expected 0", e); end
`endif
    checks++;
    if (rd_cnt[0] !== 16'(exp_rd[0])) begin errors++; $display("[TB] FAIL oor_rd_count: got %0d expected %0d", rd_cnt[0], exp_rd[0]); end
    checks++;
    if (wr_cnt[0] !== 16'(exp_wr[0])) begin errors++; $display("[TB] FAIL oor_wr_count: got %0d expected %0d", wr_cnt[0], exp_wr[0]); end
  endtask

  task automatic test_input_hold;
    logic [31:0] rd, rdn, expv; int lat; logic rn, e;
    run_txn(1, 32'h080, 32'h13572468, 4'hF, 1'b1, rd, lat, rn, rdn, e);
    exp_wr[1]++;
    checks++;
    if (lat != 4) begin errors++; $display("[TB] FAIL hold_wr_latency: got %0d expected 4", lat); end
    exp_q.push_back(32'h13572468);
    run_txn(1, 32'h080, 32'h0, 4'h0, 1'b1, rd, lat, rn, rdn, e);
    exp_rd[1]++;
    expv = exp_q.pop_front();
    checks++;
    if (lat != 4) begin errors++; $display("[TB] FAIL hold_rd_latency: got %0d expected 4", lat); end
    checks++;
    if (rd !== expv) begin errors++; $display("[TB] FAIL hold_rdata: got %h expected %h", rd, expv); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, rdn, expv; int lat; logic rn, e;
    run_txn(1, 32'h040, 32'hCAFEF00D, 4'hF, 1'b0, rd, lat, rn, rdn, e);
    @(negedge clk);
    addr[1] = 32'h040; wdata[1] = 32'h0BADBAD0; wstrb[1] = 4'hF; valid[1] = 1'b1;
    @(negedge clk);
    #2;
    rst[1] = 1'b1; valid[1] = 1'b0;
    #1;
    exp_rd[1] = 0;
    exp_wr[1] = 0;
    checks++;
    if (rd_cnt[1] !== 16'h0) begin errors++; $display("[TB] FAIL abort_rd_count: got %h expected 0", rd_cnt[1]); end
    checks++;
    if (wr_cnt[1] !== 16'h0) begin errors++; $display("[TB] FAIL abort_wr_count: got %h expected 0", wr_cnt[1]); end
    @(negedge clk);
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ready[1] !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_ready: got %b expected 0 at cycle %0d", ready[1], i); end
    end
    exp_q.push_back(32'hCAFEF00D);
    run_txn(1, 32'h040, 32'h0, 4'h0, 1'b0, rd, lat, rn, rdn, e);
    exp_rd[1]++;
    expv = exp_q.pop_front();
    checks++;
    if (lat != 4) begin errors++; $display("[TB] FAIL abort_rd_latency: got %0d expected 4", lat); end
    checks++;
    if (rd !== expv) begin errors++; $display("[TB] FAIL abort_rdata: got %h expected %h", rd, expv); end
    checks++;
    if (wr_cnt[1] !== 16'(exp_wr[1])) begin errors++; $display("[TB] FAIL abort_wr_after: got %0d expected %0d", wr_cnt[1], exp_wr[1]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, rdn, expv; int lat; logic rn, e; logic exp_ready;
    run_txn(2, 32'h000, 32'h55AA33CC, 4'hF, 1'b0, rd, lat, rn, rdn, e);
    exp_wr[2]++;
    checks++;
    if (lat != 1) begin errors++; $display("[TB] FAIL b2b_wr_latency: got %0d expected 1", lat); end
    @(negedge clk);
    addr[2] = 32'h000; wdata[2] = 32'h0; wstrb[2] = 4'h0; valid[2] = 1'b1;
    exp_q.push_back(32'h55AA33CC);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      exp_ready = (i % 3 == 1);
      checks++;
      if (ready[2] !== exp_ready) begin errors++; $display("[TB] FAIL b2b_ready: got %b expected %b at cycle %0d", ready[2], exp_ready, i); end
      if (ready[2] === 1'b1 && exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        exp_rd[2]++;
        checks++;
        if (rdata[2] !== expv) begin errors++; $display("[TB] FAIL b2b_rdata: got %h expected %h", rdata[2], expv); end
      end
      if (i % 3 == 0 && i < 28) exp_q.push_back(32'h55AA33CC);
    end
    valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_cnt[2] !== 16'(exp_rd[2])) begin errors++; $display("[TB] FAIL b2b_rd_count: got %0d expected %0d", rd_cnt[2], exp_rd[2]); end
  endtask

  task automatic test_random;
    logic [31:0] rd, rdn, expv, d32; int lat; logic rn, e;
    logic [31:0] model [16];
    int idx; logic [3:0] s;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      run_txn(0, 32'(i * 4), model[i], 4'hF, 1'b0, rd, lat, rn, rdn, e);
    end
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, 15);
      s   = 4'($urandom_range(0, 15));
      d32 = $urandom;
      if (s == 4'h0) exp_q.push_back(model[idx]);
      run_txn(0, 32'(idx * 4 + $urandom_range(0, 3)), d32, s, 1'b0, rd, lat, rn, rdn, e);
      checks++;
      if (lat != 2) begin errors++; $display("[TB] FAIL rand_latency: got %0d expected 2", lat); end
      if (s == 4'h0) begin
        expv = exp_q.pop_front();
        checks++;
        if (rd !== expv) begin errors++; $display("[TB] FAIL rand_rdata[%0d]: got %h expected %h", idx, rd, expv); end
      end else begin
        for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d32[8*b +: 8];
      end
    end
  endtask

  task automatic test_saturation;
    logic [31:0] rd, rdn, expv; int lat; logic rn, e; int wr_before;
    wr_before = exp_wr[2];
    @(negedge clk);
    force u_ws0.rd_count = 16'hFFFC;
    #1;
    release u_ws0.rd_count;
    exp_rd[2] = 32'hFFFC;
    for (int n = 0; n < 6; n++) begin
      exp_q.push_back(32'h55AA33CC);
      run_txn(2, 32'h000, 32'h0, 4'h0, 1'b0, rd, lat, rn, rdn, e);
      if (exp_rd[2] != 32'hFFFF) exp_rd[2]++;
      expv = exp_q.pop_front();
      checks++;
      if (rd !== expv) begin errors++; $display("[TB] FAIL sat_rdata: got %h expected %h", rd, expv); end
      checks++;
      if (rd_cnt[2] !== 16'(exp_rd[2])) begin errors++; $display("[TB] FAIL sat_rd_count: got %h expected %h", rd_cnt[2], 16'(exp_rd[2])); end
    end
    checks++;
    if (wr_cnt[2] !== 16'(wr_before)) begin errors++; $display("[TB] FAIL sat_wr_count: got %0d expected %0d", wr_cnt[2], wr_before); end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0; valid[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; wstrb[d] = 4'h0;
    end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_input_hold();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
